// File: rtl/alu_operand_loader_pkg.sv
// ============================================================================
// alu_operand_loader_pkg : shared state encodings, opcodes and control-word
//                          bit positions for the ALU operand loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_operand_loader_pkg;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    GET_CTL = 2'd2,
    ISSUE   = 2'd3
  } state_t;

  // Control-word layout: select in bit 0, opcode starting at bit 1.
  localparam int SEL_BIT = 0;
  localparam int OP_LSB  = 1;

  localparam logic [1:0] OPC_ADD = 2'd0;
  localparam logic [1:0] OPC_SUB = 2'd1;
  localparam logic [1:0] OPC_AND = 2'd2;
  localparam logic [1:0] OPC_OR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_operand_loader_if.sv
// ============================================================================
// alu_operand_loader_if : input beat bus plus issued operand-set handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_operand_loader_if
  import alu_operand_loader_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 2,
  parameter int CNTW  = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sel;
  logic [OPW-1:0]   op_code;
  logic             op_valid;
  logic             op_ready;
  logic             busy;
  logic [CNTW-1:0]  op_count;

  // Loader side.
  modport slave (
    input  in_valid, in_data, op_ready,
    output in_ready, op_a, op_b, op_sel, op_code, op_valid, busy, op_count
  );

  // Environment side: upstream beat source and downstream consumer.
  modport master (
    output in_valid, in_data, op_ready,
    input  in_ready, op_a, op_b, op_sel, op_code, op_valid, busy, op_count
  );

endinterface

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ============================================================================
// alu_operand_loader : gathers A, B and control beats into a registered
//                      operand set and issues it with valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 2,
  parameter int CNTW  = 8
)(
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_loader_if.slave  bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_sel;
  logic [OPW-1:0]   r_op_code;
  logic [CNTW-1:0]  r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= GET_A;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_sel   <= 1'b0;
      r_op_code  <= '0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        GET_A: begin
          if (bus.in_valid) begin
            r_op_a  <= bus.in_data;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (bus.in_valid) begin
            r_op_b  <= bus.in_data;
            r_state <= GET_CTL;
          end
        end
        GET_CTL: begin
          // Control-word bits above the opcode field are dropped here.
          if (bus.in_valid) begin
            r_op_sel  <= bus.in_data[SEL_BIT];
            r_op_code <= bus.in_data[OP_LSB +: OPW];
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.op_ready) begin
            r_op_count <= r_op_count + CNTW'(1);
            r_state    <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

  // Handshake flags decode straight from the state register, so the input
  // bus is stalled exactly while the operand set is being offered.
  assign bus.in_ready = (r_state != ISSUE);
  assign bus.op_valid = (r_state == ISSUE);
  assign bus.busy     = (r_state != GET_A);

  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.op_sel   = r_op_sel;
  assign bus.op_code  = r_op_code;
  assign bus.op_count = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// tb_alu_operand_loader : directed frames checked against a beat-level model
//                         plus literal expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

  localparam int WIDTH = 4;
  localparam int OPW   = 2;
  localparam int CNTW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_loader_if #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) bus ();

  alu_operand_loader #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: number of beats taken in the current frame plus the fields seen.
  int         acc;
  logic [3:0] ma, mb;
  logic       msel;
  logic [1:0] mcode;
  logic [7:0] mcnt;

  always @(posedge clk) begin
    if (rst) begin
      acc <= 0; ma <= 4'h0; mb <= 4'h0; msel <= 1'b0; mcode <= 2'd0; mcnt <= 8'd0;
    end else if (acc < 3) begin
      if (bus.in_valid) begin
        if (acc == 0)      ma <= bus.in_data;
        else if (acc == 1) mb <= bus.in_data;
        else begin
          msel  <= bus.in_data[0];
          mcode <= bus.in_data[2:1];
        end
        acc <= acc + 1;
      end
    end else if (bus.op_ready) begin
      mcnt <= mcnt + 8'd1;
      acc  <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", 32'(bus.in_ready), 32'(acc < 3));
      check("m_op_valid", 32'(bus.op_valid), 32'(acc == 3));
      check("m_busy",     32'(bus.busy),     32'(acc != 0));
      check("m_op_a",     32'(bus.op_a),     32'(ma));
      check("m_op_b",     32'(bus.op_b),     32'(mb));
      check("m_op_sel",   32'(bus.op_sel),   32'(msel));
      check("m_op_code",  32'(bus.op_code),  32'(mcode));
      check("m_op_count", 32'(bus.op_count), 32'(mcnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: in_ready stuck at %b, required 1", bus.in_ready);
    end
    tick();
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    beat(a);
    beat(b);
    beat(c);
    bus.in_valid = 1'b0;
  endtask

  logic [3:0] gap_data [6] = '{4'h3, 4'hE, 4'hE, 4'hC, 4'hE, 4'h0};
  logic [5:0] gap_vld = 6'b101001;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    bus.op_ready = 1'b0;

    // Reset
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_op_a",     32'(bus.op_a),     32'h0);
    check("rst_op_b",     32'(bus.op_b),     32'h0);
    check("rst_op_valid", 32'(bus.op_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_busy",     32'(bus.busy),     32'h0);
    check("rst_op_count", 32'(bus.op_count), 32'h0);

    // Back-to-back frame, consumer always ready
    bus.op_ready = 1'b1;
    frame(4'h5, 4'hA, 4'b0011);
    check("b2b_op_valid", 32'(bus.op_valid), 32'h1);
    check("b2b_op_a",     32'(bus.op_a),     32'h5);
    check("b2b_op_b",     32'(bus.op_b),     32'hA);
    check("b2b_op_sel",   32'(bus.op_sel),   32'h1);
    check("b2b_op_code",  32'(bus.op_code),  32'h1);
    check("b2b_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check("b2b_valid_1cyc", 32'(bus.op_valid), 32'h0);
    check("b2b_op_count",   32'(bus.op_count), 32'h1);

    // Backpressure: 5 stalled cycles with junk on the input bus
    bus.op_ready = 1'b0;
    frame(4'h5, 4'hA, 4'b0011);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_op_valid", 32'(bus.op_valid), 32'h1);
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_op_a",     32'(bus.op_a),     32'h5);
      check("bp_op_b",     32'(bus.op_b),     32'hA);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b1;
    check("bp_op_valid_6", 32'(bus.op_valid), 32'h1);
    tick();
    check("bp_done_valid", 32'(bus.op_valid), 32'h0);
    check("bp_op_count",   32'(bus.op_count), 32'h2);

    // Gapped input
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = gap_vld[i];
      bus.in_data  = gap_data[i];
      tick();
      if (i == 2) begin
        check("gap_busy",  32'(bus.busy),     32'h1);
        check("gap_hold",  32'(bus.op_valid), 32'h0);
      end
    end
    bus.in_valid = 1'b0;
    check("gap_op_valid", 32'(bus.op_valid), 32'h1);
    check("gap_op_a",     32'(bus.op_a),     32'h3);
    check("gap_op_b",     32'(bus.op_b),     32'hC);
    check("gap_op_sel",   32'(bus.op_sel),   32'h0);
    tick();
    check("gap_op_count", 32'(bus.op_count), 32'h3);

    // Reset mid-frame
    beat(4'h7);
    beat(4'h9);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",  32'(bus.busy),     32'h0);
    check("mid_rst_op_a",  32'(bus.op_a),     32'h0);
    frame(4'h1, 4'h2, 4'b0101);
    check("mid_op_a",    32'(bus.op_a),    32'h1);
    check("mid_op_b",    32'(bus.op_b),    32'h2);
    check("mid_op_sel",  32'(bus.op_sel),  32'h1);
    check("mid_op_code", 32'(bus.op_code), 32'h2);
    tick();
    check("mid_op_count", 32'(bus.op_count), 32'h1);

    // Counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      frame(4'(i), 4'(~i), 4'(i));
      tick();
    end
    check("wrap_op_count_0", 32'(bus.op_count), 32'h0);
    frame(4'h1, 4'h1, 4'h1);
    tick();
    check("wrap_op_count_1", 32'(bus.op_count), 32'h1);

    // Selector: (a,b) over all 1-bit pairs, each with sel 0 and 1
    for (int k = 0; k < 8; k++) begin
      logic [3:0] a, b, c, exp;
      a   = {3'b000, 1'(k)};
      b   = {3'b000, 1'(k >> 1)};
      c   = {3'b000, 1'(k >> 2)};
      exp = (k >= 4) ? b : a;
      frame(a, b, c);
      check("selector", 32'(bus.op_sel ? bus.op_b : bus.op_a), 32'(exp));
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
